// File: rtl/sclk_sched_pkg.sv
// ---------------------------------------------------------------------------
// sclk_sched_pkg
// Shared types and constants for the shared serial-clock scheduler:
//   state_t       burst FSM state encoding
//   DIV_W_DEF     default half-period field width (clk cycles)
//   LEN_W_DEF     default burst-length field width (sclk rising edges)
//   N_REQ         number of requesters
//   req_onehot()  requester index -> one-hot requester vector
// ---------------------------------------------------------------------------
package sclk_sched_pkg;

    localparam int unsigned DIV_W_DEF = 8;
    localparam int unsigned LEN_W_DEF = 8;
    localparam int unsigned N_REQ     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Index of a requester expanded to its bit in a per-requester vector.
    function automatic logic [N_REQ-1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage : sclk_sched_pkg

// File: rtl/sclk_sched_rr.sv
// ---------------------------------------------------------------------------
// sclk_sched_rr
// Two-way round-robin picker, purely combinational.
//   req    in   per-requester request level
//   last   in   index of the most recently granted requester
//   grant  out  one-hot winner, all zero when nobody requests
// A lone requester always wins; on contention the requester that was not
// granted last time wins.
// ---------------------------------------------------------------------------
module sclk_sched_rr
    import sclk_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             last,
    output logic [N_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule : sclk_sched_rr

// File: rtl/sclk_sched.sv
// ---------------------------------------------------------------------------
// sclk_sched
// Arbitrates two requesters for a shared serial clock and generates one
// burst of sclk_o for the winner.
//   clk_i          in   system clock, rising edge
//   rst_n_i        in   asynchronous active-low reset
//   req_i          in   per-requester burst request (level, held until ack)
//   div0_i/div1_i  in   half-period in clk cycles per requester, 0 acts as 1
//   len0_i/len1_i  in   sclk high phases per requester, 0 = empty burst
//   ack_o          out  one-cycle pulse, request accepted and fields latched
//   done_o         out  one-cycle pulse, owner's burst finished
//   busy_o         out  high from the ack cycle through the done cycle
//   owner_o        out  current / last granted requester
//   sclk_o         out  shared serial clock, idle low
//   sclk_rise_o    out  strobe in the first cycle of each sclk high phase
// ---------------------------------------------------------------------------
module sclk_sched
    import sclk_sched_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic [DIV_W-1:0] div0_i,
    input  logic [DIV_W-1:0] div1_i,
    input  logic [LEN_W-1:0] len0_i,
    input  logic [LEN_W-1:0] len1_i,
    output logic [N_REQ-1:0] ack_o,
    output logic [N_REQ-1:0] done_o,
    output logic             busy_o,
    output logic             owner_o,
    output logic             sclk_o,
    output logic             sclk_rise_o
);

    state_t           state_q;
    logic             last_q;     // last granted requester, drives priority
    logic [DIV_W-1:0] div_q;      // latched half-period (never 0)
    logic [LEN_W-1:0] len_q;      // latched burst length
    logic [DIV_W-1:0] cnt_q;      // cycles left in the current phase, minus one
    logic [LEN_W-1:0] phase_q;    // high phases started so far

    logic [N_REQ-1:0] grant;
    logic             win_idx;
    logic [DIV_W-1:0] win_div;
    logic [LEN_W-1:0] win_len;

    sclk_sched_rr u_rr (
        .req   (req_i),
        .last  (last_q),
        .grant (grant)
    );

    // Fields of the would-be winner, with a zero divider promoted to one.
    always_comb begin
        win_idx = grant[1];
        win_div = win_idx ? div1_i : div0_i;
        win_len = win_idx ? len1_i : len0_i;
        if (win_div == '0) begin
            win_div = DIV_W'(1);
        end
    end

    // Burst FSM; every output is a register updated alongside the state.
    // Priority starts at requester 0 by making requester 1 the "last" one.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            div_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            phase_q     <= '0;
            ack_o       <= '0;
            done_o      <= '0;
            busy_o      <= 1'b0;
            owner_o     <= 1'b0;
            sclk_o      <= 1'b0;
            sclk_rise_o <= 1'b0;
        end else begin
            ack_o       <= '0;
            done_o      <= '0;
            sclk_rise_o <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (|grant) begin
                        owner_o <= win_idx;
                        last_q  <= win_idx;
                        div_q   <= win_div;
                        len_q   <= win_len;
                        cnt_q   <= win_div - DIV_W'(1);
                        phase_q <= '0;
                        ack_o   <= grant;
                        busy_o  <= 1'b1;
                        state_q <= (win_len == '0) ? ST_DONE : ST_LOW;
                    end
                end

                ST_LOW: begin
                    if (cnt_q == '0) begin
                        sclk_o      <= 1'b1;
                        sclk_rise_o <= 1'b1;
                        cnt_q       <= div_q - DIV_W'(1);
                        phase_q     <= phase_q + LEN_W'(1);
                        state_q     <= ST_HIGH;
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end

                ST_HIGH: begin
                    if (cnt_q == '0) begin
                        sclk_o <= 1'b0;
                        cnt_q  <= div_q - DIV_W'(1);
                        if (phase_q == len_q) begin
                            done_o  <= req_onehot(owner_o);
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_LOW;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end

                ST_DONE: begin
                    // Entered with done_o already pulsing after a real burst;
                    // an empty burst arrives here in its ack cycle and
                    // spends one more cycle to pulse done_o.
                    if (|done_o) begin
                        busy_o  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        done_o <= req_onehot(owner_o);
                    end
                end

                default: begin
                    sclk_o  <= 1'b0;
                    busy_o  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : sclk_sched
